// File: rtl/mm_stream_master_if.sv
// Command/response streams and Avalon-MM bus of mm_stream_master; the master modport is the block side,
// the slave modport is the host/interconnect side.
interface mm_stream_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
) ();
   logic                cmd_valid;
   logic                cmd_ready;
   logic [1:0]          cmd_op;
   logic [ADDR_W-1:0]   cmd_addr;
   logic [LEN_W-1:0]    cmd_len;
   logic [DATA_W-1:0]   cmd_data;

   logic                rsp_valid;
   logic                rsp_ready;
   logic [DATA_W-1:0]   rsp_data;
   logic                rsp_error;

   logic [ADDR_W-1:0]   master_address;
   logic                master_read;
   logic                master_write;
   logic [DATA_W-1:0]   master_writedata;
   logic [DATA_W/8-1:0] master_byteenable;
   logic [DATA_W-1:0]   master_readdata;
   logic                master_waitrequest;
   logic                master_readdatavalid;
   logic                master_reset_reset;

   modport master (
      input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data, rsp_ready,
             master_readdata, master_waitrequest, master_readdatavalid,
      output cmd_ready, rsp_valid, rsp_data, rsp_error,
             master_address, master_read, master_write, master_writedata,
             master_byteenable, master_reset_reset
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data, rsp_ready,
             master_readdata, master_waitrequest, master_readdatavalid,
      input  cmd_ready, rsp_valid, rsp_data, rsp_error,
             master_address, master_read, master_write, master_writedata,
             master_byteenable, master_reset_reset
   );
endinterface

// File: rtl/mm_stream_master.sv
// Command-stream Avalon-MM master: registered outputs, reads throttled by response-FIFO credit, FIFO latency 1.
// Optional waitrequest watchdog with timeout filler responses under MM_MASTER_TIMEOUT_EN.
module mm_stream_master #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int LEN_W          = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int RESET_CYCLES   = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic               clk_clk,
   input  logic               clk_reset_reset,
   mm_stream_master_if.master bus
);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int SW  = CW + 1;
   localparam int RW  = LEN_W + 1;
   localparam int RCW = $clog2(RESET_CYCLES + 1);
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
   localparam logic [2:0] S_WDATA = 3'd2;
   localparam logic [2:0] S_READ  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;
   localparam logic [2:0] S_RST   = 3'd5;

   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_RESET = 2'd2;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DATA_W % 8 != 0 ||
       RESET_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("mm_stream_master: illegal parameter set");
   end

   logic [2:0]        state, state_nxt;
   logic [RW-1:0]     rem, rem_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic [DATA_W-1:0] wdata_q, wdata_nxt;
   logic [RCW-1:0]    rst_cnt, rst_cnt_nxt;
   logic [CW-1:0]     outst, outst_nxt, occ, occ_nxt;
   logic [AW-1:0]     wptr, rptr, rptr_nxt;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [DATA_W-1:0] rsp_data_q, head_dat, push_dat;
   logic              cmd_ready_q, rsp_valid_q, rd_q, wr_q, sys_rst_q;
   logic              cmd_fire, wr_done, rd_issue, push_rd, fill, push, pop, credit_nxt;
   logic              tmo_hit, tmo_mode, tmo_mode_nxt;

   assign cmd_fire = bus.cmd_valid & cmd_ready_q;
   assign wr_done  = (state == S_WRITE) & wr_q & ~bus.master_waitrequest;
   assign rd_issue = rd_q & ~bus.master_waitrequest;
   // Read data with nothing outstanding is a stale return (e.g. after reset) and is dropped.
   assign push_rd  = bus.master_readdatavalid & (outst != '0);
   // Fillers wait for real returns so response order matches address order.
   assign fill     = tmo_mode & (state == S_READ) & (rem != '0) & (outst == '0) &
                     (occ != CW'(FIFO_DEPTH));
   assign push     = push_rd | fill;
   assign push_dat = push_rd ? bus.master_readdata : '0;
   assign pop      = rsp_valid_q & bus.rsp_ready;

   assign outst_nxt  = outst + CW'(rd_issue) - CW'(push_rd);
   assign occ_nxt    = occ + CW'(push) - CW'(pop);
   assign rptr_nxt   = rptr + AW'(pop);
   assign head_dat   = (occ == CW'(pop)) ? push_dat : mem[rptr_nxt];
   assign credit_nxt = (SW'(outst_nxt) + SW'(occ_nxt)) < SW'(FIFO_DEPTH);

   always_comb begin
      state_nxt    = state;
      rem_nxt      = rem;
      addr_nxt     = addr_q;
      wdata_nxt    = wdata_q;
      rst_cnt_nxt  = rst_cnt;
      tmo_mode_nxt = tmo_mode;
      case (state)
         S_IDLE: if (cmd_fire) begin
            addr_nxt     = bus.cmd_addr;
            wdata_nxt    = bus.cmd_data;
            rem_nxt      = (bus.cmd_len == '0) ? RW'(1) : {1'b0, bus.cmd_len};
            tmo_mode_nxt = 1'b0;
            rst_cnt_nxt  = RCW'(RESET_CYCLES - 1);
            case (bus.cmd_op)
               OP_WRITE: state_nxt = S_WRITE;
               OP_READ:  state_nxt = S_READ;
               OP_RESET: state_nxt = S_RST;
               default:  state_nxt = S_IDLE;
            endcase
         end
         S_WRITE: if (wr_done || tmo_hit) begin
            rem_nxt      = rem - 1'b1;
            tmo_mode_nxt = tmo_hit;
            if (rem == RW'(1)) begin
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_WDATA;
               addr_nxt  = addr_q + STEP;
            end
         end
         S_WDATA: if (cmd_fire) begin
            // After a write timeout the rest of the command's beats are swallowed.
            if (tmo_mode) begin
               rem_nxt = rem - 1'b1;
               if (rem == RW'(1)) state_nxt = S_IDLE;
            end else begin
               wdata_nxt = bus.cmd_data;
               state_nxt = S_WRITE;
            end
         end
         S_READ: begin
            if (rd_issue || fill) begin
               rem_nxt = rem - 1'b1;
               if (rd_issue) addr_nxt = addr_q + STEP;
               if (rem == RW'(1)) state_nxt = S_DRAIN;
            end else if (tmo_hit) begin
               tmo_mode_nxt = 1'b1;
            end
         end
         S_DRAIN: if (outst == '0) state_nxt = S_IDLE;
         S_RST: begin
            if (rst_cnt == '0) state_nxt = S_IDLE;
            else rst_cnt_nxt = rst_cnt - 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_clk or posedge clk_reset_reset) begin
      if (clk_reset_reset) begin
         state       <= S_IDLE;
         rem         <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rst_cnt     <= '0;
         tmo_mode    <= 1'b0;
         outst       <= '0;
         occ         <= '0;
         wptr        <= '0;
         rptr        <= '0;
         cmd_ready_q <= 1'b0;
         wr_q        <= 1'b0;
         rd_q        <= 1'b0;
         sys_rst_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state       <= state_nxt;
         rem         <= rem_nxt;
         addr_q      <= addr_nxt;
         wdata_q     <= wdata_nxt;
         rst_cnt     <= rst_cnt_nxt;
         tmo_mode    <= tmo_mode_nxt;
         outst       <= outst_nxt;
         occ         <= occ_nxt;
         rptr        <= rptr_nxt;
         if (push) wptr <= wptr + 1'b1;
         cmd_ready_q <= (state_nxt == S_IDLE) || (state_nxt == S_WDATA);
         wr_q        <= (state_nxt == S_WRITE);
         // Credit counts every issued read, so a pending request is never withdrawn.
         rd_q        <= (state_nxt == S_READ) && !tmo_mode_nxt && credit_nxt;
         sys_rst_q   <= (state_nxt == S_RST);
         rsp_valid_q <= (occ_nxt != '0);
         rsp_data_q  <= head_dat;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (push) mem[wptr] <= push_dat;
   end

`ifdef MM_MASTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]         tmo_cnt;
   logic [FIFO_DEPTH-1:0] mem_err;
   logic                  stall, rsp_error_q;

   assign stall   = (rd_q | wr_q) & bus.master_waitrequest;
   assign tmo_hit = stall & (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_clk or posedge clk_reset_reset) begin
      if (clk_reset_reset) begin
         tmo_cnt     <= '0;
         mem_err     <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         tmo_cnt <= (stall && !tmo_hit) ? tmo_cnt + 1'b1 : '0;
         if (push) mem_err[wptr] <= fill;
         rsp_error_q <= (occ == CW'(pop)) ? fill : mem_err[rptr_nxt];
      end
   end

   assign bus.rsp_error = rsp_error_q;
`else
   assign tmo_hit       = 1'b0;
   assign bus.rsp_error = 1'b0;
`endif

   assign bus.cmd_ready          = cmd_ready_q;
   assign bus.rsp_valid          = rsp_valid_q;
   assign bus.rsp_data           = rsp_data_q;
   assign bus.master_address     = addr_q;
   assign bus.master_read        = rd_q;
   assign bus.master_write       = wr_q;
   assign bus.master_writedata   = wdata_q;
   assign bus.master_byteenable  = '1;
   assign bus.master_reset_reset = sys_rst_q;
endmodule

// File: doc/mm_stream_master.md
# mm_stream_master

Parametrised command-stream-driven Avalon-MM master: the next generation of our console master, sitting between a host command channel and the system interconnect. It accepts word-wide command beats and performs single or multi-word incrementing writes and pipelined reads. It pulses a system reset on request and returns read data through a buffered response stream. Address/data widths, burst length, outstanding-read depth and reset pulse length are configurable.

## Interface
- ADDR_W, 32, master address width (byte address)
- DATA_W, 32, data width; multiple of 8
- LEN_W, 8, width of burst-length field
- FIFO_DEPTH, 4, response FIFO entries; also the cap on outstanding reads plus buffered responses (power of 2, ≥2)
- RESET_CYCLES, 16, master_reset_reset pulse length
- TIMEOUT_CYCLES, 1024, waitrequest watchdog limit (used only with MM_MASTER_TIMEOUT_EN)

- clk_clk  in  1  single clock
- clk_reset_reset  in  1  asynchronous, active-high reset
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_op  in  2  00 WRITE, 01 READ, 10 RESET, 11 NOP
- cmd_addr  in  ADDR_W  start byte address
- cmd_len  in  LEN_W  word count; 0 treated as 1
- cmd_data  in  DATA_W  write data
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake
- rsp_data  out  DATA_W  read word
- rsp_error  out  1  word is a timeout filler (always 0 without the macro)
- master_address  out  ADDR_W; master_read, master_write  out  1; master_writedata  out  DATA_W; master_byteenable  out  DATA_W/8, all ones
- master_readdata  in  DATA_W; master_waitrequest, master_readdatavalid  in  1
- master_reset_reset  out  1  system reset pulse

## Operation
- States: IDLE, WRITE, WDATA, READ, DRAIN, RST.
- IDLE: cmd_ready=1. Beat accepted on cmd_valid&cmd_ready; op selects next state. NOP consumes the beat and stays in IDLE.
- WRITE: master_write=1 with latched address/data until a cycle with waitrequest=0. Then remaining=remaining-1. If zero → IDLE, else → WDATA with address += DATA_W/8.
- WDATA: cmd_ready=1. The next beat supplies only cmd_data (other fields ignored) → WRITE.
- READ: master_read=1 while credit exists: outstanding + FIFO occupancy < FIFO_DEPTH. If credit is absent, master_read=0 (no stall of an issued request). Each accepted read increments outstanding, address += DATA_W/8. After the last issue → DRAIN.
- DRAIN: wait until outstanding=0 → IDLE. Commands are never overlapped.
- readdatavalid pushes master_readdata into the FIFO and decrements outstanding, in any state.
- RST: master_reset_reset=1 for exactly RESET_CYCLES cycles → IDLE. The FIFO is kept.
- Address arithmetic wraps modulo 2^ADDR_W. The remaining counter is LEN_W+1 bits.
- Simultaneous push and pop: both occur, occupancy unchanged. Credit rule guarantees the FIFO never overflows. Read data arriving unexpectedly (outstanding=0) is dropped.

## Timing
- Reset values: cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_error=0, master_read=0, master_write=0, master_address=0, master_writedata=0, master_reset_reset=0, FIFO empty, outstanding=0, state IDLE. cmd_ready rises the first cycle after reset deasserts.
- All outputs are registered. Command accepted at edge N → master_read/write asserted from edge N+1.
- Back-to-back reads: one per cycle when waitrequest=0 and credit exists.
- readdatavalid at edge N → rsp_valid at edge N+1 (FIFO latency 1).
- rsp_data/rsp_error are held stable while rsp_valid=1 and rsp_ready=0.
- Reset mid-operation: immediate return to reset values. In-flight reads and FIFO contents are discarded.

## Configuration
- MM_MASTER_TIMEOUT_EN defined: a counter tracks consecutive cycles with (master_read|master_write)&master_waitrequest. Reaching TIMEOUT_CYCLES:
  - The request is deasserted.
  - For writes, remaining data beats of the command are accepted and discarded.
  - For reads, each un-issued word is pushed as rsp_data=0, rsp_error=1, subject to credit.
  - The block then proceeds to DRAIN/IDLE.
- Not defined: the counter is absent, waits are unbounded, and rsp_error is tied 0.

## Test plan
- WRITE addr=0x100 len=3, data 0xA,0xB,0xC, waitrequest=0 → three writes at 0x100/0x104/0x108 with matching data, byteenable=0xF.
- READ addr=0x200 len=8, FIFO_DEPTH=4, rsp_ready=0 → exactly 4 reads issued, then master_read=0. Raising rsp_ready → remaining 4 issued, 8 responses in order.
- waitrequest held 5 cycles on a write → master_address/master_writedata stable throughout, a single write completes.
- RESET op → master_reset_reset high exactly 16 cycles, then cmd_ready=1.
- clk_reset_reset asserted mid-READ with 2 outstanding → all outputs at reset values, late readdatavalid ignored, rsp_valid stays 0.
- With MM_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8, READ len=3 with waitrequest stuck → request dropped after 8 cycles, 3 responses with rsp_error=1, data 0.
